reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer sitting directly downstream of instruction issue; allocates one entry per issued instruction at the tail.
- Collects results from the ALU and LSB common data buses, and commits in program order at the head, one instruction per cycle.
- Commit targets: regfile write, store release to LSB, or misprediction flush plus PC redirect to IF.
- Exports head, tail and empty so issue can detect full; exports operand lookup ports for RS/LSB rename resolution.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
IDX_W, 4, log2(ROB_SIZE); equals `ROBIdxWidth

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low = hold all state, no commit
issue_en_in  input  1  allocate entry at tail this cycle
issue_instr_id_in  input  `InstrIdWidth  decoded instruction id
issue_rd_in  input  5  destination register
issue_pred_pc_in  input  32  predicted next PC of the issued instruction
alu_cdb_en_in  input  1  ALU broadcast valid
alu_cdb_idx_in  input  IDX_W  ROB index of ALU result
alu_cdb_val_in  input  32  ALU result (link value for JAL/JALR)
alu_cdb_pc_in  input  32  actual next PC (branches/jumps; pc+4 otherwise)
lsb_cdb_en_in  input  1  LSB broadcast valid (load data, or store address ready)
lsb_cdb_idx_in  input  IDX_W  ROB index
lsb_cdb_val_in  input  32  load data (ignored for stores)
qj_idx_in, qk_idx_in  input  IDX_W  operand lookup indices
qj_ready_out, qk_ready_out  output  1  entry value available
qj_val_out, qk_val_out  output  32  entry value
rob_empty_out  output  1  buffer empty
rob_head_out, rob_tail_out  output  IDX_W  head/tail pointers
commit_reg_en_out  output  1  regfile write this cycle
commit_rd_out  output  5  destination register
commit_val_out  output  32  write value
commit_idx_out  output  IDX_W  committing ROB index (rename-tag clear)
commit_store_en_out  output  1  release head store in LSB
flush_out  output  1  misprediction flush, one-cycle pulse
redirect_pc_out  output  32  correct fetch PC, valid with flush_out

Behaviour:
- Reset: head=tail=0, empty=1, all entry ready bits 0, every pulse output 0, commit data 0, redirect_pc 0.
- Full = (head==tail && !empty). Issue guarantees issue_en_in is never asserted when full; the ROB does not re-check it.
- Issue: entry[tail] <- {id, rd, pred_pc, ready=0}; tail <- tail+1 (mod ROB_SIZE); empty <- 0.
- CDB: a write to idx sets val, actual_pc and ready=1 on the next edge. Both buses in the same cycle to different indices: both write.
- Lookup ports are combinational.
  - Ready = entry.ready, or same-cycle CDB match (ALU then LSB), with the bypassed value.
  - Index outside the occupied range: don't-care.
- Commit, when !empty && entry[head].ready && rdy_in:
  - Load/ALU/LUI/AUIPC/JAL/JALR with rd!=0: commit_reg_en_out=1 with rd/val/idx, for exactly that cycle.
  - Store (SB..SW): commit_store_en_out=1; no reg write.
  - Branch/jump with actual_pc != pred_pc: flush_out=1, redirect_pc_out=actual_pc. The instruction's own reg write still commits in the same cycle. All entries are invalidated; head=tail=0; empty=1 on the next edge.
  - Otherwise head <- head+1. empty <- 1 if head+1==tail and no issue this cycle.
- A CDB write to the head entry commits no earlier than the following cycle (1-cycle minimum result-to-commit).
- Simultaneous issue and commit: both take effect; empty stays 0 when there is an issue.
- Flush has priority: any issue or CDB write in the flush cycle is discarded. Upstream also flushes on flush_out.
- rdy_in low: no state change, all pulse outputs 0; lookup outputs remain valid.
- Reset mid-operation behaves as the reset state; no pending commit is emitted.
- Pointer arithmetic is IDX_W-bit modular; wrap from ROB_SIZE-1 to 0 is implicit.

Decomposition:
- config.vh holds: `ROBSize, `ROBIdxWidth, `InstrIdWidth, instruction id constants (LB..LHU, SB..SW, BEQ..BGEU, JAL, JALR, LUI, AUIPC), `TRUE/`FALSE/`ZERO.
- No sub-module. Entry storage is per-field register arrays inside reorder_buffer; commit and flush logic stay local.

Test Plan:
- Reset then no issue -> rob_empty_out=1, head=tail=0, no pulses.
- Issue ADDI rd=5 at idx0; ALU CDB idx0 val=0x2A next cycle -> commit_reg_en_out=1, rd=5, val=0x2A, idx=0, exactly one cycle later; empty=1 after.
- Issue 16 entries with no CDB -> head=tail=0, empty=0 (full). Complete idx0; commit; issue one more -> tail wraps to 1, head=1.
- Issue SW then ADD; CDB both out of order (ADD first) -> ADD waits; SW commit_store_en_out first, then ADD reg write on the next cycle.
- BEQ pred_pc=0x104, ALU CDB actual_pc=0x200, three younger entries present -> flush_out=1, redirect_pc_out=0x200; next cycle empty=1, head=tail=0, younger entries never commit.
- qj_idx_in=3 while ALU CDB writes idx3 val=0x77 in the same cycle -> qj_ready_out=1, qj_val_out=0x77 combinationally.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants, instruction ids and commit classification for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned RobSize      = 16;
  localparam int unsigned RobIdxWidth  = 4;
  localparam int unsigned InstrIdWidth = 6;

  typedef logic [InstrIdWidth-1:0] instr_id_t;

  // Decoded instruction ids as produced by the decoder.
  localparam instr_id_t IdNop   = 6'd0;
  localparam instr_id_t IdLui   = 6'd1;
  localparam instr_id_t IdAuipc = 6'd2;
  localparam instr_id_t IdJal   = 6'd3;
  localparam instr_id_t IdJalr  = 6'd4;
  localparam instr_id_t IdBeq   = 6'd5;
  localparam instr_id_t IdBne   = 6'd6;
  localparam instr_id_t IdBlt   = 6'd7;
  localparam instr_id_t IdBge   = 6'd8;
  localparam instr_id_t IdBltu  = 6'd9;
  localparam instr_id_t IdBgeu  = 6'd10;
  localparam instr_id_t IdLb    = 6'd11;
  localparam instr_id_t IdLh    = 6'd12;
  localparam instr_id_t IdLw    = 6'd13;
  localparam instr_id_t IdLbu   = 6'd14;
  localparam instr_id_t IdLhu   = 6'd15;
  localparam instr_id_t IdSb    = 6'd16;
  localparam instr_id_t IdSh    = 6'd17;
  localparam instr_id_t IdSw    = 6'd18;
  localparam instr_id_t IdAddi  = 6'd19;
  localparam instr_id_t IdSlti  = 6'd20;
  localparam instr_id_t IdSltiu = 6'd21;
  localparam instr_id_t IdXori  = 6'd22;
  localparam instr_id_t IdOri   = 6'd23;
  localparam instr_id_t IdAndi  = 6'd24;
  localparam instr_id_t IdSlli  = 6'd25;
  localparam instr_id_t IdSrli  = 6'd26;
  localparam instr_id_t IdSrai  = 6'd27;
  localparam instr_id_t IdAdd   = 6'd28;
  localparam instr_id_t IdSub   = 6'd29;
  localparam instr_id_t IdSll   = 6'd30;
  localparam instr_id_t IdSlt   = 6'd31;
  localparam instr_id_t IdSltu  = 6'd32;
  localparam instr_id_t IdXor   = 6'd33;
  localparam instr_id_t IdSrl   = 6'd34;
  localparam instr_id_t IdSra   = 6'd35;
  localparam instr_id_t IdOr    = 6'd36;
  localparam instr_id_t IdAnd   = 6'd37;

  // What an instruction does when it reaches the head.
  typedef enum logic [1:0] {
    ClassReg,     // loads, ALU ops, LUI/AUIPC: register write only
    ClassStore,   // release the store to the LSB
    ClassBranch,  // conditional branch: may redirect, never writes rd
    ClassJump     // JAL/JALR: writes link value and may redirect
  } instr_class_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] val;
  } lookup_t;

  function automatic instr_class_t classify(input instr_id_t id);
    if (id inside {[IdSb:IdSw]}) begin
      return ClassStore;
    end else if (id inside {[IdBeq:IdBgeu]}) begin
      return ClassBranch;
    end else if (id == IdJal || id == IdJalr) begin
      return ClassJump;
    end
    return ClassReg;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate at tail, out-of-order completion via the
// ALU/LSB CDBs, in-order commit at head with misprediction flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE = RobSize,
  parameter int unsigned IDX_W    = RobIdxWidth
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_en_in,
  input  instr_id_t        issue_instr_id_in,
  input  logic [4:0]       issue_rd_in,
  input  logic [31:0]      issue_pred_pc_in,
  input  logic             alu_cdb_en_in,
  input  logic [IDX_W-1:0] alu_cdb_idx_in,
  input  logic [31:0]      alu_cdb_val_in,
  input  logic [31:0]      alu_cdb_pc_in,
  input  logic             lsb_cdb_en_in,
  input  logic [IDX_W-1:0] lsb_cdb_idx_in,
  input  logic [31:0]      lsb_cdb_val_in,
  input  logic [IDX_W-1:0] qj_idx_in,
  input  logic [IDX_W-1:0] qk_idx_in,
  output logic             qj_ready_out,
  output logic [31:0]      qj_val_out,
  output logic             qk_ready_out,
  output logic [31:0]      qk_val_out,
  output logic             rob_empty_out,
  output logic [IDX_W-1:0] rob_head_out,
  output logic [IDX_W-1:0] rob_tail_out,
  output logic             commit_reg_en_out,
  output logic [4:0]       commit_rd_out,
  output logic [31:0]      commit_val_out,
  output logic [IDX_W-1:0] commit_idx_out,
  output logic             commit_store_en_out,
  output logic             flush_out,
  output logic [31:0]      redirect_pc_out
);

  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

  // Per-field entry storage.
  instr_id_t     id_q      [ROB_SIZE];
  logic [4:0]    rd_q      [ROB_SIZE];
  logic [31:0]   pred_pc_q [ROB_SIZE];
  logic [31:0]   val_q     [ROB_SIZE];
  logic [31:0]   pc_q      [ROB_SIZE];
  logic [ROB_SIZE-1:0] ready_q;

  logic [IDX_W-1:0] head_q, tail_q, head_inc;
  logic             empty_q;

  instr_class_t head_class;
  logic         commit_ok, mispredict, flush, reg_en, store_en;
  lookup_t      qj_res, qk_res;

  // Head decode: decide what, if anything, commits this cycle.
  always_comb begin
    head_inc   = head_q + IdxOne;
    head_class = classify(id_q[head_q]);
    // Reset gates commit so a pending head never leaks out while state is being cleared.
    commit_ok  = !rst_in && rdy_in && !empty_q && ready_q[head_q];
    mispredict = (head_class == ClassBranch || head_class == ClassJump) &&
                 (pc_q[head_q] != pred_pc_q[head_q]);
    flush      = commit_ok && mispredict;
    reg_en     = commit_ok && (head_class == ClassReg || head_class == ClassJump) &&
                 (rd_q[head_q] != 5'd0);
    store_en   = commit_ok && (head_class == ClassStore);
  end

  // Commit and redirect outputs; data lines are zero whenever their strobe is low.
  always_comb begin
    commit_reg_en_out   = reg_en;
    commit_rd_out       = reg_en ? rd_q[head_q] : 5'd0;
    commit_val_out      = reg_en ? val_q[head_q] : 32'd0;
    commit_idx_out      = reg_en ? head_q : '0;
    commit_store_en_out = store_en;
    flush_out           = flush;
    redirect_pc_out     = flush ? pc_q[head_q] : 32'd0;
    rob_empty_out       = empty_q;
    rob_head_out        = head_q;
    rob_tail_out        = tail_q;
  end

  // Operand lookup with same-cycle CDB bypass, ALU taking precedence over LSB.
  function automatic lookup_t lookup(input logic [IDX_W-1:0] idx);
    lookup_t r;
    r.ready = ready_q[idx];
    r.val   = val_q[idx];
    if (!ready_q[idx]) begin
      if (rdy_in && alu_cdb_en_in && alu_cdb_idx_in == idx) begin
        r.ready = 1'b1;
        r.val   = alu_cdb_val_in;
      end else if (rdy_in && lsb_cdb_en_in && lsb_cdb_idx_in == idx) begin
        r.ready = 1'b1;
        r.val   = lsb_cdb_val_in;
      end
    end
    return r;
  endfunction

  // Drive both lookup ports.
  always_comb begin
    qj_res       = lookup(qj_idx_in);
    qk_res       = lookup(qk_idx_in);
    qj_ready_out = qj_res.ready;
    qj_val_out   = qj_res.val;
    qk_ready_out = qk_res.ready;
    qk_val_out   = qk_res.val;
  end

  // Pointers, empty flag and per-entry ready bits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      empty_q <= 1'b1;
      ready_q <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        // Flush wins over any issue or CDB write arriving in the same cycle.
        head_q  <= '0;
        tail_q  <= '0;
        empty_q <= 1'b1;
        ready_q <= '0;
      end else begin
        if (commit_ok) begin
          head_q <= head_inc;
        end
        if (issue_en_in) begin
          tail_q          <= tail_q + IdxOne;
          empty_q         <= 1'b0;
          ready_q[tail_q] <= 1'b0;
        end else if (commit_ok && head_inc == tail_q) begin
          empty_q <= 1'b1;
        end
        if (alu_cdb_en_in) begin
          ready_q[alu_cdb_idx_in] <= 1'b1;
        end
        if (lsb_cdb_en_in) begin
          ready_q[lsb_cdb_idx_in] <= 1'b1;
        end
      end
    end
  end

  // Entry payload; contents are only meaningful while the matching entry is occupied.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush) begin
      if (issue_en_in) begin
        id_q[tail_q]      <= issue_instr_id_in;
        rd_q[tail_q]      <= issue_rd_in;
        pred_pc_q[tail_q] <= issue_pred_pc_in;
      end
      if (alu_cdb_en_in) begin
        val_q[alu_cdb_idx_in] <= alu_cdb_val_in;
        pc_q[alu_cdb_idx_in]  <= alu_cdb_pc_in;
      end
      if (lsb_cdb_en_in) begin
        val_q[lsb_cdb_idx_in] <= lsb_cdb_val_in;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based program-order model plus directed vectors.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_en;
  instr_id_t   issue_id;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred;
  logic        alu_en, lsb_en;
  logic [3:0]  alu_idx, lsb_idx, qj_idx, qk_idx;
  logic [31:0] alu_val, alu_pc, lsb_val;
  logic        qj_ready, qk_ready, rob_empty, c_reg_en, c_store_en, flush;
  logic [31:0] qj_val, qk_val, c_val, redirect_pc;
  logic [3:0]  rob_head, rob_tail, c_idx;
  logic [4:0]  c_rd;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .issue_en_in(issue_en), .issue_instr_id_in(issue_id), .issue_rd_in(issue_rd),
    .issue_pred_pc_in(issue_pred),
    .alu_cdb_en_in(alu_en), .alu_cdb_idx_in(alu_idx), .alu_cdb_val_in(alu_val),
    .alu_cdb_pc_in(alu_pc),
    .lsb_cdb_en_in(lsb_en), .lsb_cdb_idx_in(lsb_idx), .lsb_cdb_val_in(lsb_val),
    .qj_idx_in(qj_idx), .qk_idx_in(qk_idx),
    .qj_ready_out(qj_ready), .qj_val_out(qj_val),
    .qk_ready_out(qk_ready), .qk_val_out(qk_val),
    .rob_empty_out(rob_empty), .rob_head_out(rob_head), .rob_tail_out(rob_tail),
    .commit_reg_en_out(c_reg_en), .commit_rd_out(c_rd), .commit_val_out(c_val),
    .commit_idx_out(c_idx), .commit_store_en_out(c_store_en),
    .flush_out(flush), .redirect_pc_out(redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: the queue front is the oldest in-flight instruction.
  typedef struct {
    int          idx;
    instr_id_t   id;
    logic [4:0]  rd;
    logic [31:0] pred_pc;
    bit          ready;
    logic [31:0] val;
    logic [31:0] pc;
  } ent_t;

  ent_t rob[$];
  int   m_head = 0;

  function automatic int find(input int idx);
    foreach (rob[i]) if (rob[i].idx == idx) return i;
    return -1;
  endfunction

  task automatic lookup_chk(input string nm, input int idx, input logic act_rdy,
                            input logic [31:0] act_val);
    int          p;
    bit          er;
    logic [31:0] ev;
    p = find(idx);
    if (p < 0) return;
    er = rob[p].ready;
    ev = rob[p].val;
    if (!er && rdy && alu_en && int'(alu_idx) == idx) begin
      er = 1; ev = alu_val;
    end else if (!er && rdy && lsb_en && int'(lsb_idx) == idx) begin
      er = 1; ev = lsb_val;
    end
    chk({nm, "_ready"}, act_rdy, er);
    if (er) chk({nm, "_val"}, act_val, ev);
  endtask

  task automatic model_cycle();
    bit   c, is_st, is_cond, is_ctrl, e_reg, e_store, e_flush;
    int   tail_b;
    ent_t h, n;
    tail_b  = (m_head + rob.size()) % 16;
    c       = !rst && rdy && rob.size() > 0 && rob[0].ready;
    e_reg   = 0;
    e_store = 0;
    e_flush = 0;
    if (c) begin
      h       = rob[0];
      is_st   = h.id inside {IdSb, IdSh, IdSw};
      is_cond = h.id inside {IdBeq, IdBne, IdBlt, IdBge, IdBltu, IdBgeu};
      is_ctrl = is_cond || h.id == IdJal || h.id == IdJalr;
      e_store = is_st;
      e_reg   = !is_st && !is_cond && h.rd != 5'd0;
      e_flush = is_ctrl && h.pc != h.pred_pc;
    end
    chk("empty", rob_empty, rob.size() == 0);
    chk("head", rob_head, m_head);
    chk("tail", rob_tail, tail_b);
    chk("reg_en", c_reg_en, e_reg);
    chk("rd", c_rd, e_reg ? h.rd : 5'd0);
    chk("val", c_val, e_reg ? h.val : 32'd0);
    chk("idx", c_idx, e_reg ? 32'(h.idx) : 32'd0);
    chk("store_en", c_store_en, e_store);
    chk("flush", flush, e_flush);
    chk("redirect", redirect_pc, e_flush ? h.pc : 32'd0);
    lookup_chk("qj", int'(qj_idx), qj_ready, qj_val);
    lookup_chk("qk", int'(qk_idx), qk_ready, qk_val);

    if (rst) begin
      rob.delete();
      m_head = 0;
    end else if (rdy) begin
      if (e_flush) begin
        rob.delete();
        m_head = 0;
      end else begin
        foreach (rob[i]) begin
          if (alu_en && rob[i].idx == int'(alu_idx)) begin
            rob[i].ready = 1; rob[i].val = alu_val; rob[i].pc = alu_pc;
          end
          if (lsb_en && rob[i].idx == int'(lsb_idx)) begin
            rob[i].ready = 1; rob[i].val = lsb_val;
          end
        end
        if (c) begin
          void'(rob.pop_front());
          m_head = (m_head + 1) % 16;
        end
        if (issue_en) begin
          n.idx = tail_b; n.id = issue_id; n.rd = issue_rd; n.pred_pc = issue_pred;
          n.ready = 0; n.val = 0; n.pc = 0;
          rob.push_back(n);
        end
      end
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model past the next edge.
  always @(negedge clk) begin
    if (started) model_cycle();
  end

  task automatic clear_inputs();
    rdy = 1; issue_en = 0; issue_id = IdNop; issue_rd = 0; issue_pred = 0;
    alu_en = 0; alu_idx = 0; alu_val = 0; alu_pc = 0;
    lsb_en = 0; lsb_idx = 0; lsb_val = 0; qj_idx = 0; qk_idx = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input instr_id_t id, input logic [4:0] rd, input logic [31:0] pred);
    issue_en = 1; issue_id = id; issue_rd = rd; issue_pred = pred;
  endtask

  task automatic alu(input logic [3:0] idx, input logic [31:0] val, input logic [31:0] pc);
    alu_en = 1; alu_idx = idx; alu_val = val; alu_pc = pc;
  endtask

  task automatic lsb(input logic [3:0] idx, input logic [31:0] val);
    lsb_en = 1; lsb_idx = idx; lsb_val = val;
  endtask

  task automatic do_reset();
    tick(); rst = 1;
    tick(); rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    started = 1;
    tick(); rst = 0; settle();
    chk("rst_empty", rob_empty, 1);
    chk("rst_head", rob_head, 0);
    chk("rst_tail", rob_tail, 0);
    chk("rst_pulses", {c_reg_en, c_store_en, flush}, 0);

    // Single ADDI: result one cycle, commit the next.
    tick(); issue(IdAddi, 5'd5, 32'h104);
    tick(); alu(4'd0, 32'h2A, 32'h104); settle();
    chk("addi_early", c_reg_en, 0);
    tick(); settle();
    chk("addi_en", c_reg_en, 1);
    chk("addi_rd", c_rd, 5);
    chk("addi_val", c_val, 32'h2A);
    chk("addi_idx", c_idx, 0);
    tick(); settle();
    chk("addi_empty", rob_empty, 1);
    chk("addi_once", c_reg_en, 0);

    // Fill all 16 entries, then drain one and wrap the tail.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(); issue(IdAdd, 5'(i + 1), 32'h1000 + 32'(4 * i));
    end
    tick(); alu(4'd0, 32'h11, 32'h1004); settle();
    chk("full_head", rob_head, 0);
    chk("full_tail", rob_tail, 0);
    chk("full_empty", rob_empty, 0);
    tick(); settle();
    chk("full_commit_idx", c_idx, 0);
    chk("full_commit_val", c_val, 32'h11);
    tick(); issue(IdAdd, 5'd20, 32'h2000); settle();
    tick(); settle();
    chk("wrap_tail", rob_tail, 1);
    chk("wrap_head", rob_head, 1);

    // rdy low holds commit; reset then drops a pending commit.
    tick(); alu(4'd1, 32'h22, 32'h1008);
    tick(); rdy = 0; settle();
    chk("hold_commit", c_reg_en, 0);
    tick(); settle();
    chk("hold_release", c_val, 32'h22);
    tick(); lsb(4'd2, 32'h33);
    tick(); rst = 1; settle();
    chk("rst_no_commit", c_reg_en, 0);
    tick(); rst = 0; settle();
    chk("rst_mid_empty", rob_empty, 1);

    // Store then ADD, completed out of order; issue alongside the store commit.
    do_reset();
    tick(); issue(IdSw, 5'd0, 32'h2004);
    tick(); issue(IdAdd, 5'd7, 32'h2008);
    tick(); alu(4'd1, 32'h99, 32'h2008);
    tick(); lsb(4'd0, 32'h0); settle();
    chk("ooo_wait", {c_reg_en, c_store_en}, 0);
    tick(); issue(IdAddi, 5'd9, 32'h200C); settle();
    chk("sw_store", c_store_en, 1);
    chk("sw_noreg", c_reg_en, 0);
    tick(); settle();
    chk("add_after_sw", c_val, 32'h99);
    chk("add_rd", c_rd, 7);
    tick(); settle();
    chk("issue_commit_empty", rob_empty, 0);

    // Mispredicted BEQ with three younger entries; both CDBs fire together first.
    do_reset();
    tick(); issue(IdBeq, 5'd0, 32'h104);
    tick(); issue(IdAdd, 5'd3, 32'h108);
    tick(); issue(IdAdd, 5'd4, 32'h10C);
    tick(); issue(IdAdd, 5'd6, 32'h110);
    tick(); alu(4'd0, 32'h0, 32'h200); lsb(4'd1, 32'h55);
    tick(); issue(IdAdd, 5'd8, 32'h114); alu(4'd2, 32'h66, 32'h110); settle();
    chk("beq_flush", flush, 1);
    chk("beq_redirect", redirect_pc, 32'h200);
    tick(); settle();
    chk("post_flush_empty", rob_empty, 1);
    chk("post_flush_tail", rob_tail, 0);
    tick(); tick(); settle();
    chk("young_dead", c_reg_en, 0);

    // Correctly predicted BNE just retires.
    tick(); issue(IdBne, 5'd0, 32'h40);
    tick(); alu(4'd0, 32'h0, 32'h40);
    tick(); settle();
    chk("bne_noflush", flush, 0);
    tick(); settle();
    chk("bne_head", rob_head, 1);

    // Mispredicted JAL writes its link value in the flush cycle.
    tick(); issue(IdJal, 5'd1, 32'h300);
    tick(); alu(4'd1, 32'h104, 32'h500);
    tick(); settle();
    chk("jal_flush", flush, 1);
    chk("jal_redirect", redirect_pc, 32'h500);
    chk("jal_link", c_val, 32'h104);
    chk("jal_rd", c_rd, 1);

    // Lookup bypass and stored values.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); issue(IdAdd, 5'(10 + i), 32'h400 + 32'(4 * i));
    end
    tick(); qj_idx = 4'd3; qk_idx = 4'd2; alu(4'd3, 32'h77, 32'h410); settle();
    chk("qj_bypass_ready", qj_ready, 1);
    chk("qj_bypass_val", qj_val, 32'h77);
    chk("qk_not_ready", qk_ready, 0);
    tick(); qj_idx = 4'd3; qk_idx = 4'd1; lsb(4'd1, 32'hABC); settle();
    chk("qj_stored_val", qj_val, 32'h77);
    chk("qk_lsb_val", qk_val, 32'hABC);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
